// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a valid/ready
// handshake and a one-entry skid buffer. Every output, in_ready included, is a
// flop output, so the downstream stall has no combinational path back upstream.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall_cnt and flush_cnt
// outputs.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CHANNELS    = 6,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [15:0]                flush_cnt
`endif
);

  localparam int unsigned BUS_W = CHANNELS * DATA_W;

  logic             skid_valid;
  logic [BUS_W-1:0] skid_data;

  logic             out_valid_n;
  logic [BUS_W-1:0] out_data_n;
  logic             skid_valid_n;
  logic [BUS_W-1:0] skid_data_n;
  logic             in_ready_n;
  logic             in_fire;
  logic             drain;

  // Next-state selection for the main and skid slots.
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    in_fire      = in_valid & in_ready;
    drain        = !out_valid | out_ready;

    if (flush) begin
      // Any input taken this cycle is dropped along with both slots.
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
      if (ZERO_BUBBLE) begin
        out_data_n  = '0;
        skid_data_n = '0;
      end
    end else if (drain) begin
      if (skid_valid) begin
        // The skid entry is older than anything upstream, so it goes first.
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        skid_valid_n = 1'b0;
        if (ZERO_BUBBLE) begin
          skid_data_n = '0;
        end
      end else begin
        out_valid_n = in_valid;
        if (in_valid) begin
          out_data_n = in_data;
        end else if (ZERO_BUBBLE) begin
          out_data_n = '0;
        end
      end
    end else if (in_fire) begin
      // The main slot is stalled, so park the new item in the skid slot.
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end

    in_ready_n = !skid_valid_n;
  end

  // State registers; a synchronous reset empties both slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= in_ready_n;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; only rst clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= 32'(stall_cnt + 32'd1);
      end
      if (flush && (out_valid || skid_valid) && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= 16'(flush_cnt + 16'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg. It uses two instances: the
// default geometry with zero bubbles, and a narrow 3x8 build that holds its data.
module tb_pipe_stage_reg;

  localparam int unsigned A_W = 6 * 32;
  localparam int unsigned B_W = 3 * 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] out_data;

  logic           b_flush;
  logic           b_in_valid;
  logic           b_in_ready;
  logic [B_W-1:0] b_in_data;
  logic           b_out_valid;
  logic           b_out_ready;
  logic [B_W-1:0] b_out_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [31:0] b_stall_cnt;
  logic [15:0] b_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(8), .CHANNELS(3), .ZERO_BUBBLE(1'b0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (b_stall_cnt),
    .flush_cnt (b_flush_cnt)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a channel-0-only word on instance A.
  task automatic drive_a(input logic v, input logic [31:0] d0);
    in_valid = v;
    in_data  = '0;
    in_data[31:0] = d0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_perf got=%h/%h exp=0/0", stall_cnt, flush_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, vals[i]);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data[31:0] !== vals[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1",
                 i, out_valid, out_data[31:0], in_ready, vals[i]);
      end
    end
    drive_a(1'b0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL stream_bubble got v=%b d=%h exp v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_channels();
    logic [A_W-1:0] pat;
    for (int k = 0; k < 6; k++) begin
      pat[k*32 +: 32] = 32'hC0DE_0000 | 32'(k + 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pat;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== pat) begin
      errors++; $display("FAIL channels got v=%b d=%h exp v=1 d=%h", out_valid, out_data, pat);
    end
    drive_a(1'b0, 32'h0);
    step();
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    drive_a(1'b1, 32'hA);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== 32'hA || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_load got v=%b d=%h r=%b exp v=1 d=a r=1",
                         out_valid, out_data[31:0], in_ready);
    end
    drive_a(1'b1, 32'hB);
    step();
    checks++;
    if (out_data[31:0] !== 32'hA || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_skid got d=%h r=%b exp d=a r=0", out_data[31:0], in_ready);
    end
    drive_a(1'b1, 32'hC);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== 32'hB || in_ready !== 1'b1) begin
      errors++; $display("FAIL release_b got v=%b d=%h r=%b exp v=1 d=b r=1",
                         out_valid, out_data[31:0], in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== 32'hC) begin
      errors++; $display("FAIL release_c got v=%b d=%h exp v=1 d=c", out_valid, out_data[31:0]);
    end
    drive_a(1'b0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL release_end got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_a(1'b1, 32'hA);
    step();
    drive_a(1'b1, 32'hB);
    step();
    drive_a(1'b1, 32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full got v=%b d=%h r=%b exp v=0 d=0 r=1",
                         out_valid, out_data, in_ready);
    end
    drive_a(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_c got v=%b d=%h exp v=0", out_valid, out_data[31:0]);
    end
    // Main stalled and skid empty: in_fire during the flush must be discarded.
    out_ready = 1'b0;
    drive_a(1'b1, 32'h44);
    step();
    drive_a(1'b1, 32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_a(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_fire got v=%b d=%h r=%b exp v=0 d=0 r=1",
                         out_valid, out_data[31:0], in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_a(1'b1, 32'hA);
    step();
    drive_a(1'b1, 32'hB);
    step();
    drive_a(1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got v=%b d=%h r=%b exp v=0 d=0 r=1",
                         out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    drive_a(1'b1, 32'h5);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== 32'h5) begin
      errors++; $display("FAIL rst_mid_after got v=%b d=%h exp v=1 d=5", out_valid, out_data[31:0]);
    end
    drive_a(1'b0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drain got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_narrow_hold();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 24'h030201;
    step();
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 24'h030201) begin
      errors++; $display("FAIL narrow_pass got v=%b d=%h exp v=1 d=030201", b_out_valid, b_out_data);
    end
    b_in_valid = 1'b0;
    b_in_data  = 24'hFFFFFF;
    step();
    checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 24'h030201) begin
      errors++; $display("FAIL narrow_hold got v=%b d=%h exp v=0 d=030201", b_out_valid, b_out_data);
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive_a(1'b1, 32'h1);
    step();
    drive_a(1'b0, 32'h0);
    step();
    step();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_stall got=%0d exp=2", stall_cnt);
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 32'h7);
      step();
      drive_a(1'b0, 32'h0);
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    checks++;
    if (flush_cnt !== 16'd3) begin
      errors++; $display("FAIL perf_flush got=%0d exp=3", flush_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 16'd3 || stall_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_empty_flush got=%0d/%0d exp=3/2", flush_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_channels();
    test_stall_skid();
    test_flush();
    test_reset_mid();
    test_narrow_hold();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
